// File: rtl/commit_cost_tracker_if.sv
// commit_cost_tracker_if: stage fire pulses and I-cache status in, commit beat out.
// CCT_TOTALS_EN adds the total_cycles / total_commits counters.
interface commit_cost_tracker_if #(
  parameter int CNT_W = 64
);
  logic             ifu_fire;
  logic             idu_fire;
  logic             exu_fire;
  logic             lsu_fire;
  logic             wbu_fire;
  logic             icache_lookup;
  logic             icache_miss;
  logic             commit_en;
  logic [CNT_W-1:0] icache_cost;
  logic [CNT_W-1:0] icache_miss_cost;
  logic [CNT_W-1:0] idu_cost;
  logic [CNT_W-1:0] exu_cost;
  logic [CNT_W-1:0] lsu_cost;
  logic [CNT_W-1:0] wbu_cost;
  logic             icache_need;
  logic             icache_hit;
  logic             order_err;
`ifdef CCT_TOTALS_EN
  logic [CNT_W-1:0] total_cycles;
  logic [CNT_W-1:0] total_commits;

  modport master (
    output ifu_fire, idu_fire, exu_fire,
    output lsu_fire, wbu_fire,
    output icache_lookup, icache_miss,
    input  commit_en, icache_cost,
    input  icache_miss_cost, idu_cost,
    input  exu_cost, lsu_cost, wbu_cost,
    input  icache_need, icache_hit,
    input  order_err,
    input  total_cycles, total_commits
  );

  modport slave (
    input  ifu_fire, idu_fire, exu_fire,
    input  lsu_fire, wbu_fire,
    input  icache_lookup, icache_miss,
    output commit_en, icache_cost,
    output icache_miss_cost, idu_cost,
    output exu_cost, lsu_cost, wbu_cost,
    output icache_need, icache_hit,
    output order_err,
    output total_cycles, total_commits
  );
`else
  modport master (
    output ifu_fire, idu_fire, exu_fire,
    output lsu_fire, wbu_fire,
    output icache_lookup, icache_miss,
    input  commit_en, icache_cost,
    input  icache_miss_cost, idu_cost,
    input  exu_cost, lsu_cost, wbu_cost,
    input  icache_need, icache_hit,
    input  order_err
  );

  modport slave (
    input  ifu_fire, idu_fire, exu_fire,
    input  lsu_fire, wbu_fire,
    input  icache_lookup, icache_miss,
    output commit_en, icache_cost,
    output icache_miss_cost, idu_cost,
    output exu_cost, lsu_cost, wbu_cost,
    output icache_need, icache_hit,
    output order_err
  );
`endif
endinterface

// File: rtl/commit_cost_tracker.sv
// commit_cost_tracker: per-stage cycle accounting, one commit beat per retire.
// Define CCT_TOTALS_EN for saturating total cycle/commit counters.
module commit_cost_tracker #(
  parameter int CNT_W = 64
) (
  input logic                  clock,
  input logic                  reset,
  commit_cost_tracker_if.slave bus
);
  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_LS, S_WB
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           stateNext;
  state_t           nextOnFire;
  logic [4:0]       fires;
  logic [4:0]       want;
  logic             accept;
  logic             wrongFire;
  logic             inIf;
  logic             commitNow;

  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] curNow;
  logic [CNT_W-1:0] missCnt;
  logic [CNT_W-1:0] missNow;
  logic             need;
  logic             needNow;

  logic [CNT_W-1:0] icCostQ;
  logic [CNT_W-1:0] missCostQ;
  logic [CNT_W-1:0] idCostQ;
  logic [CNT_W-1:0] exCostQ;
  logic [CNT_W-1:0] lsCostQ;
  logic             needQ;

  assign fires = {
    bus.wbu_fire, bus.lsu_fire,
    bus.exu_fire, bus.idu_fire,
    bus.ifu_fire
  };

  assign inIf = (state == S_IF);

  // cur holds cycles already spent; curNow includes this one
  assign curNow = (cur == MAX) ? cur : cur + ONE;

  assign missNow =
    (inIf && bus.icache_miss && missCnt != MAX)
    ? missCnt + ONE : missCnt;

  assign needNow = need | (inIf & bus.icache_lookup);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IF;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    want       = 5'b00000;
    nextOnFire = state;
    stateNext  = state;
    unique case (state)
      S_IF: begin
        want       = 5'b00001;
        nextOnFire = S_ID;
      end
      S_ID: begin
        want       = 5'b00010;
        nextOnFire = S_EX;
      end
      S_EX: begin
        want       = 5'b00100;
        nextOnFire = S_LS;
      end
      S_LS: begin
        want       = 5'b01000;
        nextOnFire = S_WB;
      end
      S_WB: begin
        want       = 5'b10000;
        nextOnFire = S_IF;
      end
      default: begin
        want       = 5'b00000;
        nextOnFire = S_IF;
      end
    endcase
    accept    = |(fires & want);
    wrongFire = |(fires & ~want);
    commitNow = accept && (state == S_WB);
    if (accept) begin
      stateNext = nextOnFire;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur       <= '0;
      missCnt   <= '0;
      need      <= 1'b0;
      icCostQ   <= '0;
      missCostQ <= '0;
      needQ     <= 1'b0;
      idCostQ   <= '0;
      exCostQ   <= '0;
      lsCostQ   <= '0;
    end else begin
      cur <= accept ? '0 : curNow;
      if (inIf && accept) begin
        icCostQ   <= curNow;
        missCostQ <= missNow;
        needQ     <= needNow;
        missCnt   <= '0;
        need      <= 1'b0;
      end else begin
        missCnt   <= missNow;
        need      <= needNow;
      end
      if (accept && state == S_ID) begin
        idCostQ <= curNow;
      end
      if (accept && state == S_EX) begin
        exCostQ <= curNow;
      end
      if (accept && state == S_LS) begin
        lsCostQ <= curNow;
      end
    end
  end

  // Commit beat: wbu cost is taken live from the fire cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.commit_en        <= 1'b0;
      bus.icache_cost      <= '0;
      bus.icache_miss_cost <= '0;
      bus.idu_cost         <= '0;
      bus.exu_cost         <= '0;
      bus.lsu_cost         <= '0;
      bus.wbu_cost         <= '0;
      bus.icache_need      <= 1'b0;
      bus.icache_hit       <= 1'b0;
      bus.order_err        <= 1'b0;
    end else begin
      bus.commit_en <= commitNow;
      bus.order_err <= bus.order_err | wrongFire;
      if (commitNow) begin
        bus.icache_cost      <= icCostQ;
        bus.icache_miss_cost <= missCostQ;
        bus.idu_cost         <= idCostQ;
        bus.exu_cost         <= exCostQ;
        bus.lsu_cost         <= lsCostQ;
        bus.wbu_cost         <= curNow;
        bus.icache_need      <= needQ;
        bus.icache_hit       <= needQ && (missCostQ == '0);
      end
    end
  end

`ifdef CCT_TOTALS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.total_cycles  <= '0;
      bus.total_commits <= '0;
    end else begin
      if (bus.total_cycles != MAX) begin
        bus.total_cycles <= bus.total_cycles + ONE;
      end
      if (commitNow && bus.total_commits != MAX) begin
        bus.total_commits <= bus.total_commits + ONE;
      end
    end
  end
`endif

endmodule
